coreid_multi: RTL and testbench

Parametrised successor to the single-string core ID register. It serves NSTR selectable, NUL-terminated ASCII strings through the ZX-UNO register interface: core ID, build date, board name, and so on. A select register chooses the active string. A text register streams that string one byte per read, wrapping after the terminator. The block sits on the ZX-UNO register bus next to the other register-mapped peripherals, and its dout/oe_n feed the bus read multiplexer.

---
 rtl/coreid_multi.sv | 107 ++++++++++
 tb/tb_coreid_multi.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coreid_multi.sv
// coreid_multi: selectable NUL-terminated ID strings on the ZX-UNO bus.
// One register picks the string, the other streams it a byte per read.
module coreid_multi #(
  parameter int NSTR = 4,
  parameter int MAXLEN = 32,
  parameter logic [NSTR*MAXLEN*8-1:0] STR_INIT = '0,
  parameter logic [7:0] ADDR_TEXT = 8'hFF,
  parameter logic [7:0] ADDR_SEL = 8'hFE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  input  logic       regaddr_changed,
  output logic [7:0] dout,
  output logic       oe_n
);

  localparam int SELW = (NSTR > 1) ? $clog2(NSTR) : 1;
  localparam int IDXW = $clog2(MAXLEN);
  localparam int ROMN = 1 << (SELW + IDXW);
  localparam logic [IDXW-1:0] LAST = IDXW'(MAXLEN - 1);

  logic [7:0] rom [ROMN];

  // Unused select codes read as empty strings
  for (genvar g = 0; g < ROMN; g++) begin : g_rom
    if (g < NSTR * MAXLEN) begin : g_b
      assign rom[g] = STR_INIT[g*8 +: 8];
    end else begin : g_z
      assign rom[g] = 8'h00;
    end
  end

  logic [SELW-1:0] sel_q, sel_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            reading_q, reading_d;
  logic            wr_d_q;

  logic       text_rd;
  logic       sel_rd;
  logic [7:0] cur_byte;
  logic       at_end;
  logic       wr_rise;
  logic       sel_ok;
  logic       unused_din;

  assign text_rd  = zxuno_regrd && (zxuno_addr == ADDR_TEXT);
  assign sel_rd   = zxuno_regrd && (zxuno_addr == ADDR_SEL);
  assign cur_byte = rom[{sel_q, idx_q}];
  assign at_end   = (cur_byte == 8'h00) || (idx_q == LAST);
  assign wr_rise  = zxuno_regwr && !wr_d_q;
  assign sel_ok   = {1'b0, din[3:0]} < 5'(NSTR);
  assign unused_din = ^din[7:4];

  // Bus read mux; silent while reset is held
  always_comb begin
    dout = 8'h00;
    oe_n = 1'b1;
    if (rst_n && text_rd) begin
      dout = cur_byte;
      oe_n = 1'b0;
    end else if (rst_n && sel_rd) begin
      dout = {at_end, 3'b000, 4'(sel_q)};
      oe_n = 1'b0;
    end
  end

  // Next state: select write > restart > advance > start read
  always_comb begin
    sel_d     = sel_q;
    idx_d     = idx_q;
    reading_d = reading_q;
    if (wr_rise && zxuno_addr == ADDR_SEL) begin
      if (sel_ok) sel_d = din[SELW-1:0];
      idx_d     = '0;
      reading_d = 1'b0;
    end else if (regaddr_changed &&
                 zxuno_addr == ADDR_TEXT) begin
      idx_d     = '0;
      reading_d = 1'b0;
    end else if (reading_q && !text_rd) begin
      idx_d     = at_end ? '0 : idx_q + 1'b1;
      reading_d = 1'b0;
    end else if (text_rd) begin
      reading_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      idx_q     <= '0;
      reading_q <= 1'b0;
      wr_d_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      reading_q <= reading_d;
      wr_d_q    <= zxuno_regwr;
    end
  end

endmodule

// File: tb/tb_coreid_multi.sv
// tb_coreid_multi: directed and random reads of coreid_multi
// against a string-level model of the register pair.
module tb_coreid_multi;

  localparam int NS = 4;
  localparam int ML = 16;
  localparam logic [ML*8-1:0] L0 = "T18-03072015";
  localparam logic [ML*8-1:0] L1 = "ZXUNO";
  localparam logic [ML*8-1:0] L2 = "BOARD-X";
  localparam logic [ML*8-1:0] L3 = "0123456789ABCDEF";

  function automatic logic [ML*8-1:0] pack(
    input logic [ML*8-1:0] lit, input int len);
    logic [ML*8-1:0] r;
    r = '0;
    for (int k = 0; k < len; k++)
      r[k*8 +: 8] = lit[(len-1-k)*8 +: 8];
    return r;
  endfunction

  localparam logic [NS*ML*8-1:0] ROM =
    {pack(L3, 16), pack(L2, 7), pack(L1, 5), pack(L0, 12)};

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic       regrd;
  logic       regwr;
  logic [7:0] din;
  logic       rac;
  logic [7:0] dout;
  logic       oe_n;

  int n_chk;
  int n_fail;

  string strs [NS];
  int    m_sel;
  int    m_idx;

  coreid_multi #(
    .NSTR(NS), .MAXLEN(ML), .STR_INIT(ROM),
    .ADDR_TEXT(8'hFF), .ADDR_SEL(8'hFE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .zxuno_addr(addr),
    .zxuno_regrd(regrd),
    .zxuno_regwr(regwr),
    .din(din),
    .regaddr_changed(rac),
    .dout(dout),
    .oe_n(oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(int s, int k);
    if (k < strs[s].len()) return strs[s][k];
    return 8'h00;
  endfunction

  function automatic logic [7:0] mstat();
    logic e;
    e = (mbyte(m_sel, m_idx) == 8'h00) || (m_idx == ML - 1);
    return {e, 3'b000, 4'(m_sel)};
  endfunction

  function automatic void m_text(logic [7:0] b);
    if (b == 8'h00 || m_idx == ML - 1) m_idx = 0;
    else m_idx = m_idx + 1;
  endfunction

  function automatic void m_write(logic [7:0] v);
    if (int'(v[3:0]) < NS) m_sel = int'(v[3:0]);
    m_idx = 0;
  endfunction

  task automatic rd(input logic [7:0] a, input int hold,
                    output logic [7:0] d, output logic o);
    @(negedge clk);
    addr = a;
    regrd = 1'b1;
    #1;
    d = dout;
    o = oe_n;
    repeat (hold) @(negedge clk);
    regrd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] v, input int hold);
    @(negedge clk);
    addr = 8'hFE;
    din = v;
    regwr = 1'b1;
    repeat (hold) @(negedge clk);
    regwr = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    addr = 8'hFF;
    rac = 1'b1;
    @(negedge clk);
    rac = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic o;
    rst_n = 1'b0;
    addr = 8'hFF;
    regrd = 1'b1;
    regwr = 1'b0;
    din = 8'h00;
    rac = 1'b0;
    #12;
    n_chk++;
    if (oe_n !== 1'b1 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: oe_n=%b dout=%h want 1/00",
               oe_n, dout);
    end
    @(negedge clk);
    regrd = 1'b0;
    rst_n = 1'b1;
    m_sel = 0;
    m_idx = 0;
    rd(8'hFE, 1, d, o);
    n_chk++;
    if (d !== mstat() || o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stat: got %h/%b want %h/0",
               d, o, mstat());
    end
    rd(8'h3C, 1, d, o);
    n_chk++;
    if (d !== 8'h00 || o !== 1'b1) begin
      n_fail++;
      $display("FAIL other_addr: got %h/%b want 00/1", d, o);
    end
  endtask

  task automatic test_string0();
    logic [7:0] d;
    logic [7:0] e;
    logic o;
    for (int i = 0; i < 14; i++) begin
      rd(8'hFF, 1, d, o);
      e = mbyte(m_sel, m_idx);
      n_chk++;
      if (d !== e || o !== 1'b0) begin
        n_fail++;
        $display("FAIL str0_rd%0d: got %h/%b want %h/0",
                 i, d, o, e);
      end
      m_text(e);
    end
  endtask

  task automatic test_select();
    logic [7:0] d;
    logic [7:0] e;
    logic o;
    wr(8'h02, 1);
    m_write(8'h02);
    rd(8'hFF, 1, d, o);
    e = mbyte(m_sel, m_idx);
    n_chk++;
    if (d !== e || d !== "B") begin
      n_fail++;
      $display("FAIL sel2_text: got %h want %h", d, e);
    end
    m_text(e);
    rd(8'hFE, 1, d, o);
    n_chk++;
    if (d !== mstat() || d !== 8'h02) begin
      n_fail++;
      $display("FAIL sel2_stat: got %h want %h", d, mstat());
    end
    wr(8'h07, 2);
    m_write(8'h07);
    rd(8'hFF, 1, d, o);
    e = mbyte(m_sel, m_idx);
    n_chk++;
    if (d !== e || d !== "B") begin
      n_fail++;
      $display("FAIL bad_sel: got %h want %h", d, e);
    end
    m_text(e);
    rd(8'hFE, 1, d, o);
    n_chk++;
    if (d !== mstat()) begin
      n_fail++;
      $display("FAIL bad_sel_stat: got %h want %h",
               d, mstat());
    end
  endtask

  task automatic test_restart();
    logic [7:0] d;
    logic [7:0] e;
    logic o;
    wr(8'h00, 1);
    m_write(8'h00);
    for (int i = 0; i < 2; i++) begin
      rd(8'hFF, 1, d, o);
      m_text(mbyte(m_sel, m_idx));
    end
    restart();
    m_idx = 0;
    rd(8'hFF, 5, d, o);
    n_chk++;
    if (d !== "T") begin
      n_fail++;
      $display("FAIL restart: got %h want 54", d);
    end
    m_text(d);
    rd(8'hFF, 1, d, o);
    e = mbyte(m_sel, m_idx);
    n_chk++;
    if (d !== e || d !== "1") begin
      n_fail++;
      $display("FAIL long_hold: got %h want %h", d, e);
    end
    m_text(e);
  endtask

  task automatic test_full();
    logic [7:0] d;
    logic [7:0] e;
    logic o;
    wr(8'h03, 1);
    m_write(8'h03);
    for (int i = 0; i < ML - 1; i++) begin
      rd(8'hFF, 1, d, o);
      e = mbyte(m_sel, m_idx);
      n_chk++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL full_rd%0d: got %h want %h", i, d, e);
      end
      m_text(e);
    end
    rd(8'hFE, 1, d, o);
    n_chk++;
    if (d !== mstat() || d !== 8'h83) begin
      n_fail++;
      $display("FAIL full_stat: got %h want 83", d);
    end
    for (int i = 0; i < 2; i++) begin
      rd(8'hFF, 1, d, o);
      e = mbyte(m_sel, m_idx);
      n_chk++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL full_wrap%0d: got %h want %h", i, d, e);
      end
      m_text(e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] v;
    logic o;
    int op;
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        rd(8'hFF, $urandom_range(1, 3), d, o);
        e = mbyte(m_sel, m_idx);
        n_chk++;
        if (d !== e || o !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_text%0d: got %h/%b want %h/0",
                   i, d, o, e);
        end
        m_text(e);
      end else if (op <= 6) begin
        rd(8'hFE, $urandom_range(1, 3), d, o);
        e = mstat();
        n_chk++;
        if (d !== e || o !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_stat%0d: got %h/%b want %h/0",
                   i, d, o, e);
        end
      end else if (op <= 8) begin
        v = 8'($urandom_range(0, 255));
        wr(v, $urandom_range(1, 3));
        m_write(v);
      end else begin
        restart();
        m_idx = 0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic o;
    wr(8'h01, 1);
    m_write(8'h01);
    rd(8'hFF, 1, d, o);
    @(negedge clk);
    addr = 8'hFF;
    regrd = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (oe_n !== 1'b1 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: oe_n=%b dout=%h want 1/00",
               oe_n, dout);
    end
    @(negedge clk);
    regrd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_sel = 0;
    m_idx = 0;
    rd(8'hFE, 1, d, o);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL post_rst_stat: got %h want 00", d);
    end
    rd(8'hFF, 1, d, o);
    n_chk++;
    if (d !== "T" || o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_text: got %h/%b want 54/0", d, o);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    strs[0] = "T18-03072015";
    strs[1] = "ZXUNO";
    strs[2] = "BOARD-X";
    strs[3] = "0123456789ABCDEF";
    test_reset();
    test_string0();
    test_select();
    test_restart();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
